usb_frame_tx: RTL and testbench
===============================

// Module: usb_frame_tx
// PURPOSE
//  Transmit side of the SDR-Micron bootloader USB framing protocol over the FT232H synchronous FIFO write path.
//  Serialises one frame per request: 7x 0x55 + 0xD5 preamble, 24-byte header (bytes 0..2 = ASCII command), optional 256-byte flash-page payload.
//  Pulses n_SIWU after the frame and reports completion by toggle. Feeds the top-level usb_data tristate alongside the command receiver.
// PARAMETERS
//  PRE_BYTES   8    preamble length incl. 0xD5 delimiter
//  HDR_BYTES   24   header length
//  PAGE_BYTES  256  payload length when tx_page=1
// PORTS
//  usb_clock   in   1    60 MHz from USB PHY; all state updates on its falling edge
//  reset       in   1    synchronous, active-high
//  tx_req      in   1    toggle: each edge requests one frame
//  tx_hdr      in   192  header; byte k = tx_hdr[191-8k -: 8], sampled at request acceptance
//  tx_page     in   1    1 = append PAGE_BYTES payload; sampled with tx_hdr
//  tx_done     out  1    toggles once per completed frame
//  busy        out  1    1 from acceptance until return to IDLE
//  rx_busy     in   1    receiver owns bus (n_RD/n_OE low); blocks frame start only
//  pg_rd_addr  out  8    payload byte address to 1-cycle-latency synchronous page RAM
//  pg_rd_data  in   8    RAM data, valid one edge after pg_rd_addr sampled
//  n_TXE       in   1    PHY TX FIFO has space (active low)
//  n_WR        out  1    write strobe (active low)
//  n_SIWU      out  1    send-immediate/wake (active low)
//  usb_dout    out  8    byte driven onto usb_data
//  usb_doe     out  1    1 = top level drives usb_data from usb_dout
// BEHAVIOUR
//  Reset: n_WR=1, n_SIWU=1, usb_doe=0, usb_dout=0, busy=0, tx_done=0, state=IDLE, byte_cnt=0, req_seen<=tx_req (no spurious frame).
//  Request pending when tx_req!=req_seen.
//  IDLE: if pending & !rx_busy & !n_TXE -> latch tx_hdr/tx_page, req_seen<=tx_req, usb_dout<=0x55, byte_cnt<=0, n_WR<=0, usb_doe<=1, busy<=1, ->PRE.
//  Accept on an edge = (n_WR==0 & n_TXE==0): PHY takes usb_dout; on accept load byte byte_cnt+1, byte_cnt++.
//  If n_TXE=1: hold usb_dout and byte_cnt; n_WR stays low; no byte lost or duplicated.
//  PRE: bytes 0..6 = 0x55, byte 7 = 0xD5; after byte 7 accepted -> HDR.
//  HDR: bytes 8..31 = header bytes 0..23; after byte 31 accepted -> PAY if tx_page, else WAKE.
//  PAY: bytes 32..287 = pg_rd_data; after byte 287 accepted -> WAKE.
//  pg_rd_addr (comb) = (byte_cnt + accept + 1 - 32)[7:0]; gives back-to-back payload at 1 byte/clock incl. HDR->PAY boundary.
//  WAKE: n_WR=1, usb_doe=0, n_SIWU=0 for exactly 1 cycle, tx_done toggles; next cycle n_SIWU=1, busy=0, ->IDLE.
//  Frame length: 32 bytes (no page) or 288 bytes; byte_cnt is 9 bits, never wraps.
//  Min frame latency from acceptance to tx_done: 32 or 288 clocks plus stall cycles.
//  rx_busy rising mid-frame is ignored; frame completes.
//  Request toggled while busy stays pending; served after return to IDLE. Two toggles while busy cancel (documented limitation).
//  Simultaneous request and reset: reset wins; req_seen tracks tx_req.
//  Reset mid-frame: bus released on that edge; PHY may hold a partial frame; host resyncs on the preamble.
//  Unused state codes -> IDLE with n_WR=1, usb_doe=0.
// STRUCTURE
//  usb_proto_pkg: PRE_BYTE=8'h55, SFD_BYTE=8'hD5, HDR_BYTES, PAGE_BYTES, command constants "ERS","WPD","SBL","RFW","RPD", state encodings.
//  No sub-module: single FSM + 9-bit counter + header shift/index mux.
//  Top level muxes usb_data: usb_doe ? usb_dout : 8'hzz; receiver and tx never drive together.
// TESTING
//  1. tx_req toggle, tx_page=0, hdr="SBL"+21x00, n_TXE=0 -> 55x7,D5,53 42 4C,00x21 on 32 consecutive accepts; one n_SIWU pulse; tx_done toggles.
//  2. tx_page=1, RAM[i]=i -> bytes 32..287 = 00..FF back-to-back; pg_rd_addr sequence correct across HDR->PAY edge.
//  3. n_TXE=1 for 3 clocks at byte 5 and again at byte 100 -> same byte stream, no drop or duplicate, total accepts 288.
//  4. rx_busy=1 when tx_req toggles -> no n_WR until rx_busy=0; second toggle during frame -> second frame follows.
//  5. reset at byte 40 -> next edge n_WR=1, usb_doe=0, tx_done=0; tx_req held 1 through reset -> no frame afterward.

Source files
------------

// File: rtl/usb_proto_pkg.sv
// usb_proto_pkg: shared constants, commands and state encodings for the bootloader USB framing
package usb_proto_pkg;
   localparam int PRE_BYTES  = 8;
   localparam int HDR_BYTES  = 24;
   localparam int PAGE_BYTES = 256;
   localparam logic [7:0] PRE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE = 8'hD5;
   localparam logic [8:0] PRE_LAST  = 9'(PRE_BYTES - 1);
   localparam logic [8:0] HDR_LAST  = 9'(PRE_BYTES + HDR_BYTES - 1);
   localparam logic [8:0] PAY_FIRST = 9'(PRE_BYTES + HDR_BYTES);
   localparam logic [8:0] PAY_LAST  = 9'(PRE_BYTES + HDR_BYTES + PAGE_BYTES - 1);
   localparam logic [23:0] CMD_ERS = "ERS";
   localparam logic [23:0] CMD_WPD = "WPD";
   localparam logic [23:0] CMD_SBL = "SBL";
   localparam logic [23:0] CMD_RFW = "RFW";
   localparam logic [23:0] CMD_RPD = "RPD";
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_HDR  = 3'd2,
      S_PAY  = 3'd3,
      S_WAKE = 3'd4
   } state_t;
endpackage

// File: rtl/usb_frame_tx.sv
// usb_frame_tx: serialises preamble, header and optional page payload onto the FT232H sync FIFO write path
module usb_frame_tx
   import usb_proto_pkg::*;
(
   input  logic         usb_clock,
   input  logic         reset,
   input  logic         tx_req,
   input  logic [191:0] tx_hdr,
   input  logic         tx_page,
   output logic         tx_done,
   output logic         busy,
   input  logic         rx_busy,
   output logic [7:0]   pg_rd_addr,
   input  logic [7:0]   pg_rd_data,
   input  logic         n_TXE,
   output logic         n_WR,
   output logic         n_SIWU,
   output logic [7:0]   usb_dout,
   output logic         usb_doe
);
   state_t       state, state_d;
   logic [8:0]   byte_cnt, cnt_d, nxt, addr_full;
   logic [191:0] hdr_q, hdr_d;
   logic [7:0]   dout_d, nxt_byte;
   logic         page_q, page_d, req_seen, seen_d, n_wr_d, siwu_d, doe_d, busy_d, done_d, accept;

   assign accept     = !n_WR && !n_TXE;
   assign nxt        = byte_cnt + 9'd1;
   // address runs one byte ahead of the bus so the 1-cycle RAM keeps up with back-to-back accepts
   assign addr_full  = byte_cnt + {8'd0, accept} + 9'd1 - PAY_FIRST;
   assign pg_rd_addr = addr_full[7:0];
   // header bytes come off the top of a shift register, so the selected byte is always [191:184]
   assign nxt_byte   = nxt < PRE_LAST ? PRE_BYTE : nxt == PRE_LAST ? SFD_BYTE :
                       nxt <= HDR_LAST ? hdr_q[191:184] : pg_rd_data;

   // next-state and next-output logic; holds everything while the PHY FIFO is full
   always_comb begin
      state_d = state;
      cnt_d   = byte_cnt;
      hdr_d   = hdr_q;
      page_d  = page_q;
      seen_d  = req_seen;
      n_wr_d  = n_WR;
      siwu_d  = n_SIWU;
      doe_d   = usb_doe;
      dout_d  = usb_dout;
      busy_d  = busy;
      done_d  = tx_done;
      case (state)
         S_IDLE: if (tx_req != req_seen && !rx_busy && !n_TXE) begin
            state_d = S_PRE;
            hdr_d   = tx_hdr;
            page_d  = tx_page;
            seen_d  = tx_req;
            dout_d  = PRE_BYTE;
            cnt_d   = 9'd0;
            n_wr_d  = 1'b0;
            doe_d   = 1'b1;
            busy_d  = 1'b1;
         end
         S_PRE, S_HDR, S_PAY: if (accept) begin
            cnt_d  = nxt;
            dout_d = nxt_byte;
            if (nxt > PRE_LAST && nxt <= HDR_LAST) hdr_d = {hdr_q[183:0], 8'h00};
            if ((state == S_HDR && byte_cnt == HDR_LAST && !page_q) || (state == S_PAY && byte_cnt == PAY_LAST)) begin
               state_d = S_WAKE;
               n_wr_d  = 1'b1;
               doe_d   = 1'b0;
               siwu_d  = 1'b0;
               done_d  = !tx_done;
            end else if (state == S_PRE && byte_cnt == PRE_LAST) state_d = S_HDR;
            else if (state == S_HDR && byte_cnt == HDR_LAST) state_d = S_PAY;
         end
         S_WAKE: begin
            siwu_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            n_wr_d  = 1'b1;
            doe_d   = 1'b0;
            siwu_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // state register on the falling edge; reset re-syncs req_seen so a held request is not replayed
   always_ff @(negedge usb_clock) begin
      if (reset) begin
         state    <= S_IDLE;
         byte_cnt <= 9'd0;
         hdr_q    <= '0;
         page_q   <= 1'b0;
         req_seen <= tx_req;
         n_WR     <= 1'b1;
         n_SIWU   <= 1'b1;
         usb_doe  <= 1'b0;
         usb_dout <= 8'h00;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_d;
         byte_cnt <= cnt_d;
         hdr_q    <= hdr_d;
         page_q   <= page_d;
         req_seen <= seen_d;
         n_WR     <= n_wr_d;
         n_SIWU   <= siwu_d;
         usb_doe  <= doe_d;
         usb_dout <= dout_d;
         busy     <= busy_d;
         tx_done  <= done_d;
      end
   end
endmodule

// File: tb/tb_usb_frame_tx.sv
// tb_usb_frame_tx: scoreboard bench for the USB frame transmitter
module tb_usb_frame_tx;
   import usb_proto_pkg::*;
   logic         usb_clock = 1'b0, reset = 1'b1, tx_req = 1'b1, tx_page = 1'b0, rx_busy = 1'b0, n_TXE = 1'b0;
   logic [191:0] tx_hdr = '0;
   logic         tx_done, busy, n_WR, n_SIWU, usb_doe;
   logic [7:0]   pg_rd_addr, usb_dout;
   logic [7:0]   pg_rd_data = 8'h00;
   logic [7:0]   exp_q[$];
   int checks = 0, failures = 0;
   int acc_idx = 0, acc_total = 0, done_cnt = 0, siwu_cnt = 0, busy_cyc = 0;
   logic done_prev = 1'b0;

   usb_frame_tx dut (
      .usb_clock(usb_clock), .reset(reset), .tx_req(tx_req), .tx_hdr(tx_hdr), .tx_page(tx_page),
      .tx_done(tx_done), .busy(busy), .rx_busy(rx_busy), .pg_rd_addr(pg_rd_addr), .pg_rd_data(pg_rd_data),
      .n_TXE(n_TXE), .n_WR(n_WR), .n_SIWU(n_SIWU), .usb_dout(usb_dout), .usb_doe(usb_doe)
   );

   always #5 usb_clock = ~usb_clock;

   // page RAM with RAM[i] = i and one edge of read latency
   always @(negedge usb_clock) pg_rd_data <= pg_rd_addr;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // monitor: samples between falling edges; a byte is taken at the next falling edge when n_WR and n_TXE are low
   always @(posedge usb_clock) begin
      #2;
      if (!reset) begin
         if (busy) busy_cyc++;
         if (!n_WR && !n_TXE) begin
            if (acc_idx >= 30 && acc_idx <= 286) chk($sformatf("pg_rd_addr@%0d", acc_idx), pg_rd_addr, (acc_idx - 30) & 255);
            chk("doe_during_write", usb_doe, 1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_byte: got %0h expected none", usb_dout);
            end else chk($sformatf("byte%0d", acc_idx), usb_dout, exp_q.pop_front());
            acc_idx++;
            acc_total++;
         end
         if (!n_SIWU) begin
            siwu_cnt++;
            chk("siwu_bus_released", {n_WR, usb_doe}, 2'b10);
         end
         if (tx_done != done_prev) begin
            done_cnt++;
            acc_idx = 0;
         end
      end
      done_prev = tx_done;
   end

   function automatic logic [191:0] mk_hdr(input logic [23:0] cmd, input int salt);
      logic [191:0] h;
      h = {cmd, 168'h0};
      for (int k = 3; k < 24; k++) h[191-8*k -: 8] = salt == 0 ? 8'h00 : 8'(k + salt);
      return h;
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge usb_clock);
   endtask

   task automatic req(input logic [191:0] h, input logic pg);
      @(posedge usb_clock);
      tx_hdr  = h;
      tx_page = pg;
      for (int k = 0; k < 7; k++) exp_q.push_back(PRE_BYTE);
      exp_q.push_back(SFD_BYTE);
      for (int k = 0; k < 24; k++) exp_q.push_back(h[191-8*k -: 8]);
      if (pg) for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
      tx_req = ~tx_req;
   endtask

   task automatic wait_done(input int target, input int budget);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge usb_clock);
         n++;
      end
      chk("tx_done_count", done_cnt, target);
   endtask

   task automatic wait_idx(input int k, input int budget);
      int n = 0;
      while (acc_idx != k && n < budget) begin
         @(posedge usb_clock);
         n++;
      end
      chk($sformatf("reach_byte%0d", k), acc_idx, k);
   endtask

   task automatic stall3();
      n_TXE = 1'b1;
      cyc(3);
      n_TXE = 1'b0;
   endtask

   initial begin
      int b0, a0;
      cyc(3);
      #2;
      chk("rst_n_WR", n_WR, 1);
      chk("rst_n_SIWU", n_SIWU, 1);
      chk("rst_doe", usb_doe, 0);
      chk("rst_dout", usb_dout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_done", tx_done, 0);
      @(posedge usb_clock);
      reset = 1'b0;
      cyc(10);
      chk("no_spurious_frame", acc_total, 0);
      // header-only frame
      b0 = busy_cyc;
      req(mk_hdr(CMD_SBL, 0), 1'b0);
      wait_done(1, 100);
      cyc(3);
      chk("t1_accepts", acc_total, 32);
      chk("t1_siwu", siwu_cnt, 1);
      chk("t1_busy_cycles", busy_cyc - b0, 33);
      chk("t1_queue_empty", exp_q.size(), 0);
      chk("t1_busy_low", busy, 0);
      // page frame, no stalls
      b0 = busy_cyc;
      req(mk_hdr(CMD_WPD, 16), 1'b1);
      wait_done(2, 400);
      cyc(3);
      chk("t2_accepts", acc_total, 320);
      chk("t2_siwu", siwu_cnt, 2);
      chk("t2_busy_cycles", busy_cyc - b0, 289);
      chk("t2_queue_empty", exp_q.size(), 0);
      // page frame with two 3-cycle stalls
      b0 = busy_cyc;
      req(mk_hdr(CMD_ERS, 64), 1'b1);
      wait_idx(5, 50);
      stall3();
      wait_idx(100, 200);
      stall3();
      wait_done(3, 400);
      cyc(3);
      chk("t3_accepts", acc_total, 608);
      chk("t3_busy_cycles", busy_cyc - b0, 295);
      chk("t3_queue_empty", exp_q.size(), 0);
      // receiver owns the bus at request time, then a second request during the frame
      rx_busy = 1'b1;
      req(mk_hdr(CMD_RFW, 100), 1'b0);
      cyc(10);
      chk("t4_blocked_accepts", acc_total, 608);
      chk("t4_blocked_busy", busy, 0);
      rx_busy = 1'b0;
      wait_idx(3, 50);
      rx_busy = 1'b1;
      req(mk_hdr(CMD_RPD, 200), 1'b0);
      wait_done(4, 100);
      cyc(5);
      chk("t4_second_held", busy, 0);
      chk("t4_first_accepts", acc_total, 640);
      rx_busy = 1'b0;
      wait_done(5, 100);
      cyc(3);
      chk("t4_accepts", acc_total, 672);
      chk("t4_siwu", siwu_cnt, 5);
      chk("t4_queue_empty", exp_q.size(), 0);
      // reset in the middle of a page frame with the request line held high
      req(mk_hdr(CMD_WPD, 32), 1'b1);
      wait_idx(40, 100);
      reset = 1'b1;
      @(posedge usb_clock);
      #3;
      chk("t5_n_WR", n_WR, 1);
      chk("t5_doe", usb_doe, 0);
      chk("t5_tx_done", tx_done, 0);
      chk("t5_busy", busy, 0);
      exp_q.delete();
      reset = 1'b0;
      a0 = acc_total;
      cyc(50);
      chk("t5_no_frame_after", acc_total, a0);
      chk("t5_idle_busy", busy, 0);
      chk("t5_n_SIWU", n_SIWU, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
